// File: rtl/seq_shifter_pkg.sv
// Shared types and helpers for the multi-cycle shift/rotate unit.
package seq_shifter_pkg;

  typedef enum logic [2:0] {
    MODE_SLL = 3'd0,
    MODE_SRL = 3'd1,
    MODE_SRA = 3'd2,
    MODE_ROL = 3'd3,
    MODE_ROR = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic mode_illegal(input logic [2:0] mode);
    return mode > 3'd4;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by k (<= STEP) positions
// and reports the last bit that left the register.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  mode_t            mode,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] next_data,
  output logic             carry
);

  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [2*WIDTH-1:0] ext;

  // The doubled vector keeps the bit just past the boundary, which is the carry.
  always_comb begin
    ext       = '0;
    next_data = data;
    carry     = 1'b0;
    case (mode)
      MODE_SLL: begin
        ext       = {ZERO, data} << k;
        next_data = ext[WIDTH-1:0];
        carry     = ext[WIDTH];
      end
      MODE_SRL: begin
        ext       = {data, ZERO} >> k;
        next_data = ext[2*WIDTH-1:WIDTH];
        carry     = ext[WIDTH-1];
      end
      MODE_SRA: begin
        ext       = $signed({data, ZERO}) >>> k;
        next_data = ext[2*WIDTH-1:WIDTH];
        carry     = ext[WIDTH-1];
      end
      MODE_ROL: begin
        ext       = {data, data} << k;
        next_data = ext[2*WIDTH-1:WIDTH];
      end
      MODE_ROR: begin
        ext       = {data, data} >> k;
        next_data = ext[WIDTH-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit with valid/ready on both sides; long
// shifts are iterated STEP positions per cycle through shift_step.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_err,
  output logic             busy
);

  localparam int KW = $clog2(STEP + 1);
  localparam logic [SHW-1:0] AMT_MAX = SHW'(WIDTH - 1);

  state_t           state, state_next, load_target;
  logic [WIDTH-1:0] data_q, step_data;
  logic [2:0]       mode_q;
  logic [SHW-1:0]   rem, amt_sat;
  logic [KW-1:0]    k;
  logic             carry_q, err_q, step_carry, accept, last_step;

  assign accept    = in_valid & in_ready;
  assign amt_sat   = (32'(in_amt) >= WIDTH) ? AMT_MAX : in_amt;
  assign last_step = 32'(rem) <= STEP;

  always_comb begin
    if (32'(rem) < STEP) k = KW'(rem);
    else                 k = KW'(STEP);
  end

  // Zero-length and illegal requests skip straight to the result stage.
  always_comb begin
    if (amt_sat == '0 || mode_illegal(in_mode)) load_target = ST_DONE;
    else                                        load_target = ST_SHIFT;
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data      (data_q),
    .mode      (mode_t'(mode_q)),
    .k         (k),
    .next_data (step_data),
    .carry     (step_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = load_target;
      ST_SHIFT: if (last_step) state_next = ST_DONE;
      ST_DONE:  if (out_ready) state_next = accept ? load_target : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      mode_q  <= 3'd0;
      rem     <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      data_q  <= in_data;
      mode_q  <= in_mode;
      rem     <= amt_sat;
      carry_q <= 1'b0;
      err_q   <= mode_illegal(in_mode);
    end else if (state == ST_SHIFT) begin
      data_q  <= step_data;
      carry_q <= step_carry;
      rem     <= rem - SHW'(k);
    end
  end

  assign out_data  = data_q;
  assign out_carry = carry_q;
  assign out_err   = err_q;

endmodule
